reg_swap_engine: RTL
====================

// Module: reg_swap_engine
// PURPOSE
//   Holds DEPTH registers of WIDTH bits. Swaps the contents of any two entries
//   with a 3-step sequence through a temporary register, driven by a small FSM.
//   Successor to the single-bit combinational swap: parametrised width and
//   depth, with a request/ready handshake and a done pulse.
//   Used as a shared swap and permute unit inside datapath register banks.
// PARAMETERS
//   WIDTH  8  data width of each entry (>=1)
//   DEPTH  4  number of entries (>=2); index width IW = $clog2(DEPTH), local
// PORTS
//   clk         in   1      clock; all state updates on rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   load_en     in   1      write load_data into entry load_idx (IDLE only)
//   load_idx    in   IW     load target index
//   load_data   in   WIDTH  load value
//   swap_req    in   1      swap request; accepted when swap_req & swap_ready
//   swap_idx_a  in   IW     first swap index, sampled on acceptance
//   swap_idx_b  in   IW     second swap index, sampled on acceptance
//   swap_ready  out  1      1 in IDLE, 0 while a swap is in flight
//   swap_done   out  1      one-cycle pulse when a swap completes
//   swap_err    out  1      pulses with swap_done if an index was >= DEPTH
//   rd_idx      in   IW     read index
//   rd_data     out  WIDTH  combinational read of entry rd_idx; 0 if >= DEPTH
// BEHAVIOUR
//   - Reset (async on rst_n=0): all entries, temp, and latched indices = 0.
//     state=IDLE, swap_ready=1, swap_done=0, swap_err=0.
//   - FSM: IDLE -> SAVE -> MOVE -> RESTORE -> IDLE. There are no other states.
//     Illegal encodings recover to IDLE.
//   - Edge E0, IDLE with swap_req=1: latch idx_a and idx_b, go to SAVE.
//     swap_ready drops after E0.
//   - Edge E1, SAVE: temp <= entry[a].
//   - Edge E2, MOVE: entry[a] <= entry[b].
//   - Edge E3, RESTORE: entry[b] <= temp, swap_done <= 1, go to IDLE.
//   - After E3: swap_done=1 and swap_ready=1 in the same cycle. swap_done
//     clears on the next edge.
//   - Acceptance to done-visible is 3 cycles. Back-to-back throughput is one
//     swap per 4 cycles: a new request can be accepted in the done cycle.
//   - Index equality (a==b): the full sequence runs and the entry ends
//     unchanged. swap_done pulses normally.
//   - Index out of range (a or b >= DEPTH; only possible for non-power-of-2
//     DEPTH): the sequence runs, but all entry writes are suppressed.
//     swap_err=1 together with swap_done.
//   - Load: load_en takes effect only when state=IDLE. In other states it is
//     ignored with no buffering. A load with load_idx >= DEPTH is ignored.
//   - Load and swap_req in the same IDLE cycle: both are honoured. The load
//     writes at E0, and SAVE at E1 sees the loaded value.
//   - rd_data during a swap shows intermediate contents. Between E2 and E3,
//     entry[a] holds the old entry[b], and both entries are equal.
//   - swap_req outside IDLE is ignored; the requester must hold it until
//     accepted.
//   - Reset asserted mid-swap aborts immediately and applies the reset values
//     above. There is no partial completion and no done pulse.
// CONFIGURATION
//   SWAP_XOR_EN defined: no temp register; XOR swap replaces the temp
//   sequence with the same states and timing:
//     SAVE:    entry[a] <= entry[a]^entry[b]
//     MOVE:    entry[b] <= entry[a]^entry[b]
//     RESTORE: entry[a] <= entry[a]^entry[b]
//   With SWAP_XOR_EN, when a==b all three writes are suppressed, so the entry
//   is not zeroed.
//   SWAP_XOR_EN undefined: the temp-register sequence above is used.
//   Port behaviour, latency, and final contents are identical in both builds.
// TESTING
//   Run every scenario in both builds, with and without SWAP_XOR_EN.
//   1. Reset, then load e0=8'hA5, e1=8'h3C. Swap (0,1) -> done 3 cycles after
//      acceptance; rd e0=8'h3C, e1=8'hA5.
//   2. e2=8'hFF. Swap (2,2) -> done pulses, e2 stays 8'hFF, swap_err=0.
//   3. Issue a second swap in the done cycle -> accepted, one swap per 4
//      cycles. Two swaps of (0,3) restore the original contents.
//   4. load_en with 8'h11 during MOVE -> ignored. Load plus swap_req in the
//      same IDLE cycle -> swap uses the loaded value.
//   5. rst_n low during RESTORE -> all entries 0, swap_ready=1, no done pulse.
//   6. DEPTH=3: swap (0,3) -> swap_done=1 and swap_err=1, entries unchanged.

Source files
------------

// File: rtl/reg_swap_engine.sv
// reg_swap_engine: DEPTH x WIDTH register bank that swaps two entries via a 4-state FSM.
// Build option: define SWAP_XOR_EN to swap with three XOR steps instead of a temp register.
module reg_swap_engine #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [IW-1:0]    load_idx,
   input  logic [WIDTH-1:0] load_data,
   input  logic             swap_req,
   input  logic [IW-1:0]    swap_idx_a,
   input  logic [IW-1:0]    swap_idx_b,
   output logic             swap_ready,
   output logic             swap_done,
   output logic             swap_err,
   input  logic [IW-1:0]    rd_idx,
   output logic [WIDTH-1:0] rd_data,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      MOVE    = 2'd2,
      RESTORE = 2'd3
   } state_t;

   // Storage is padded to a power of two so any IW-bit index is a legal array
   // index; slots at or above DEPTH are never written and never read out.
   localparam int          NSLOT   = 1 << IW;
   localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

   state_t           state, state_next;
   logic [IW-1:0]    idx_a, idx_b;
   logic [WIDTH-1:0] mem [NSLOT];
   logic             accept, idx_bad, load_ok, rd_ok;
`ifdef SWAP_XOR_EN
   logic             idx_same;
   logic [WIDTH-1:0] xab;

   assign idx_same = (idx_a == idx_b);
   assign xab      = mem[idx_a] ^ mem[idx_b];
`else
   logic [WIDTH-1:0] temp;
`endif

   assign idx_bad   = ({1'b0, idx_a} >= DEPTH_W) || ({1'b0, idx_b} >= DEPTH_W);
   assign load_ok   = load_en && ({1'b0, load_idx} < DEPTH_W);
   assign rd_ok     = ({1'b0, rd_idx} < DEPTH_W);
   assign rd_data   = rd_ok ? mem[rd_idx] : '0;
   assign state_dbg = state;

   // Handshake: a swap is accepted on the rising edge where swap_req && swap_ready;
   // the requester holds swap_req and both indices stable until that edge.
   always_comb begin
      state_next = state;
      swap_ready = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            swap_ready = 1'b1;
            if (swap_req) begin
               accept     = 1'b1;
               state_next = SAVE;
            end
         end
         SAVE:    state_next = MOVE;
         MOVE:    state_next = RESTORE;
         RESTORE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx_a     <= '0;
         idx_b     <= '0;
         swap_done <= 1'b0;
         swap_err  <= 1'b0;
`ifndef SWAP_XOR_EN
         temp      <= '0;
`endif
         for (int i = 0; i < NSLOT; i++) mem[i] <= '0;
      end else begin
         state     <= state_next;
         swap_done <= (state == RESTORE);
         swap_err  <= (state == RESTORE) && idx_bad;
         if (accept) begin
            idx_a <= swap_idx_a;
            idx_b <= swap_idx_b;
         end
         // Loads only land in IDLE, so they never collide with a swap write.
         if (state == IDLE && load_ok) mem[load_idx] <= load_data;
`ifdef SWAP_XOR_EN
         // a==b would zero the entry under XOR, so that case writes nothing.
         if (!idx_bad && !idx_same) begin
            case (state)
               SAVE:    mem[idx_a] <= xab;
               MOVE:    mem[idx_b] <= xab;
               RESTORE: mem[idx_a] <= xab;
               default: ;
            endcase
         end
`else
         case (state)
            SAVE:    temp <= mem[idx_a];
            MOVE:    if (!idx_bad) mem[idx_a] <= mem[idx_b];
            RESTORE: if (!idx_bad) mem[idx_b] <= temp;
            default: ;
         endcase
`endif
      end
   end

endmodule
